// File: rtl/seg_pkg.sv
// Shared 7-segment geometry: bit ordering, box/region offsets, digit glyphs.
package seg_pkg;

  localparam int unsigned NUM_SEGS = 7;

  // Segment bit indices within a 7-bit pattern
  localparam int unsigned SEG_TOP = 6;
  localparam int unsigned SEG_UR  = 5;
  localparam int unsigned SEG_LR  = 4;
  localparam int unsigned SEG_BOT = 3;
  localparam int unsigned SEG_LL  = 2;
  localparam int unsigned SEG_UL  = 1;
  localparam int unsigned SEG_MID = 0;

  // Digit box extent (box-relative, inclusive)
  localparam logic [10:0] BOX_DX_MAX = 11'd9;
  localparam logic [10:0] BOX_DY_MAX = 11'd19;

  // Column bands
  localparam logic [10:0] COL_L_LO = 11'd0;
  localparam logic [10:0] COL_L_HI = 11'd1;
  localparam logic [10:0] COL_C_LO = 11'd2;
  localparam logic [10:0] COL_C_HI = 11'd7;
  localparam logic [10:0] COL_R_LO = 11'd8;
  localparam logic [10:0] COL_R_HI = 11'd9;

  // Row bands
  localparam logic [10:0] ROW_T_LO = 11'd0;
  localparam logic [10:0] ROW_T_HI = 11'd1;
  localparam logic [10:0] ROW_U_LO = 11'd2;
  localparam logic [10:0] ROW_U_HI = 11'd8;
  localparam logic [10:0] ROW_M_LO = 11'd9;
  localparam logic [10:0] ROW_M_HI = 11'd10;
  localparam logic [10:0] ROW_D_LO = 11'd11;
  localparam logic [10:0] ROW_D_HI = 11'd17;
  localparam logic [10:0] ROW_B_LO = 11'd18;
  localparam logic [10:0] ROW_B_HI = 11'd19;

  // Digit glyphs, ordered {top, ur, lr, bot, ll, ul, mid}
  localparam logic [6:0] SEG_DIGIT_0  = 7'b1111110;
  localparam logic [6:0] SEG_DIGIT_1  = 7'b0110000;
  localparam logic [6:0] SEG_DIGIT_2  = 7'b1101101;
  localparam logic [6:0] SEG_DIGIT_3  = 7'b1111001;
  localparam logic [6:0] SEG_DIGIT_4  = 7'b0110011;
  localparam logic [6:0] SEG_DIGIT_5  = 7'b1011011;
  localparam logic [6:0] SEG_DIGIT_6  = 7'b1011111;
  localparam logic [6:0] SEG_DIGIT_7  = 7'b1110000;
  localparam logic [6:0] SEG_DIGIT_8  = 7'b1111111;
  localparam logic [6:0] SEG_DIGIT_9  = 7'b1111011;
  localparam logic [6:0] SEG_FALLBACK = 7'b1001001;

  localparam logic [3:0] DIGIT_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_ACCUM,
    ST_DECODE
  } state_t;

  function automatic logic in_span(input logic [10:0] v,
                                   input logic [10:0] lo,
                                   input logic [10:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Region membership of a box-relative offset, one bit per segment
  function automatic logic [6:0] seg_regions(input logic [10:0] dx,
                                             input logic [10:0] dy);
    logic [6:0] r;
    logic cl, cc, cr, rt, ru, rm, rd, rb;
    cl = in_span(dx, COL_L_LO, COL_L_HI);
    cc = in_span(dx, COL_C_LO, COL_C_HI);
    cr = in_span(dx, COL_R_LO, COL_R_HI);
    rt = in_span(dy, ROW_T_LO, ROW_T_HI);
    ru = in_span(dy, ROW_U_LO, ROW_U_HI);
    rm = in_span(dy, ROW_M_LO, ROW_M_HI);
    rd = in_span(dy, ROW_D_LO, ROW_D_HI);
    rb = in_span(dy, ROW_B_LO, ROW_B_HI);
    r = '0;
    r[SEG_TOP] = cc & rt;
    r[SEG_UR]  = cr & ru;
    r[SEG_LR]  = cr & rd;
    r[SEG_BOT] = cc & rb;
    r[SEG_LL]  = cl & rd;
    r[SEG_UL]  = cl & ru;
    r[SEG_MID] = cc & rm;
    return r;
  endfunction

  // 4-bit increment that sticks at 15
  function automatic logic [3:0] sat_inc(input logic [3:0] c, input logic hit);
    return (c == 4'hF) ? c : c + {3'b000, hit};
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational 7-segment pattern to digit lookup.
module seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] num,
  output logic       illegal
);

  // Map the ten legal glyphs; everything else (incl. fallback) is illegal
  always_comb begin
    num     = DIGIT_NONE;
    illegal = 1'b0;
    case (pattern)
      SEG_DIGIT_0: num = 4'd0;
      SEG_DIGIT_1: num = 4'd1;
      SEG_DIGIT_2: num = 4'd2;
      SEG_DIGIT_3: num = 4'd3;
      SEG_DIGIT_4: num = 4'd4;
      SEG_DIGIT_5: num = 4'd5;
      SEG_DIGIT_6: num = 4'd6;
      SEG_DIGIT_7: num = 4'd7;
      SEG_DIGIT_8: num = 4'd8;
      SEG_DIGIT_9: num = 4'd9;
      default:     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/segment_reader.sv
// Frame-level 7-segment digit recognizer observing the rendered pixel stream.
module segment_reader
  import seg_pkg::*;
#(
  parameter int unsigned HIT_MIN = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       video_on,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       pixel_on,
  input  logic [9:0] segx,
  input  logic [9:0] segy,
  input  logic       frame_tick,
  output logic [3:0] num,
  output logic [6:0] seg_pattern,
  output logic       valid,
  output logic       error
);

  localparam logic [3:0] HIT_TH = 4'(HIT_MIN);

  state_t state, state_next;

  logic accum_en, clear_live, snap_live, snap_empty, do_decode;

  logic [10:0] dx, dy;
  logic        lit_hit, in_box, stray_cell;
  logic [6:0]  seg_hit;

  logic [3:0] live_cnt [NUM_SEGS];
  logic [3:0] live_inc [NUM_SEGS];
  logic [3:0] hold_cnt [NUM_SEGS];
  logic       live_stray, live_stray_inc, hold_stray;

  logic [6:0] seg_on, seg_amb;
  logic [3:0] dec_num;
  logic       dec_illegal, dec_error;

  // Box-relative offsets; negative offsets land high and fall outside the box
  assign dx = {1'b0, x} - {1'b0, segx};
  assign dy = {1'b0, y} - {1'b0, segy};

  // Pixel qualification and region lookup
  always_comb begin
    lit_hit    = p_tick & video_on & pixel_on;
    in_box     = (dx <= BOX_DX_MAX) && (dy <= BOX_DY_MAX);
    seg_hit    = seg_regions(dx, dy);
    stray_cell = in_box & ~(|seg_hit);
  end

  // Next live counter values including the current pixel
  always_comb begin
    for (int unsigned i = 0; i < NUM_SEGS; i++) begin
      live_inc[i] = sat_inc(live_cnt[i], lit_hit & seg_hit[i]);
    end
    live_stray_inc = live_stray | (lit_hit & stray_cell);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_SYNC;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_SYNC:   if (frame_tick) state_next = ST_ACCUM;
      ST_ACCUM:  if (frame_tick) state_next = ST_DECODE;
      ST_DECODE: state_next = frame_tick ? ST_DECODE : ST_ACCUM;
      default:   state_next = ST_SYNC;
    endcase
  end

  // Control strobes per state
  always_comb begin
    accum_en   = 1'b0;
    clear_live = 1'b0;
    snap_live  = 1'b0;
    snap_empty = 1'b0;
    do_decode  = 1'b0;
    case (state)
      ST_SYNC: clear_live = 1'b1;
      ST_ACCUM: begin
        accum_en   = 1'b1;
        snap_live  = frame_tick;
        clear_live = frame_tick;
      end
      ST_DECODE: begin
        accum_en   = 1'b1;
        do_decode  = 1'b1;
        // A tick here closes a frame that has had no time to collect pixels
        snap_empty = frame_tick;
        clear_live = frame_tick;
      end
      default: clear_live = 1'b1;
    endcase
  end

  // Live per-segment counters and stray flag
  always_ff @(posedge clk) begin
    if (reset || clear_live) begin
      for (int unsigned i = 0; i < NUM_SEGS; i++) live_cnt[i] <= '0;
      live_stray <= 1'b0;
    end else if (accum_en) begin
      for (int unsigned i = 0; i < NUM_SEGS; i++) live_cnt[i] <= live_inc[i];
      live_stray <= live_stray_inc;
    end
  end

  // Frame-end snapshot; the tick-cycle pixel belongs to the ending frame
  always_ff @(posedge clk) begin
    if (reset || snap_empty) begin
      for (int unsigned i = 0; i < NUM_SEGS; i++) hold_cnt[i] <= '0;
      hold_stray <= 1'b0;
    end else if (snap_live) begin
      for (int unsigned i = 0; i < NUM_SEGS; i++) hold_cnt[i] <= live_inc[i];
      hold_stray <= live_stray_inc;
    end
  end

  // Classify each held count as ON, OFF or ambiguous
  always_comb begin
    seg_on  = '0;
    seg_amb = '0;
    for (int unsigned i = 0; i < NUM_SEGS; i++) begin
      seg_on[i]  = (hold_cnt[i] >= HIT_TH);
      seg_amb[i] = (hold_cnt[i] != '0) && (hold_cnt[i] < HIT_TH);
    end
  end

  seg_decode u_decode (
    .pattern (seg_on),
    .num     (dec_num),
    .illegal (dec_illegal)
  );

  assign dec_error = (|seg_amb) | hold_stray | dec_illegal;

  // Result registers, loaded in DECODE together with the valid pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      num         <= '0;
      seg_pattern <= '0;
      valid       <= 1'b0;
      error       <= 1'b0;
    end else begin
      valid <= do_decode;
      if (do_decode) begin
        num         <= dec_error ? DIGIT_NONE : dec_num;
        seg_pattern <= seg_on;
        error       <= dec_error;
      end
    end
  end

endmodule
